// File: rtl/muldiv_pkg.sv
// Shared types for the M-extension multiply/divide unit: operation codes,
// controller states and the operand-classification helpers.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Divide-by-zero and signed overflow finish without iterating.
    function automatic logic is_bypass(input op_e op, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] int_min;
        int_min = {1'b1, {(WIDTH-1){1'b0}}};
        return op_is_div(op) &&
               ((b == '0) || (op_b_signed(op) && (a == int_min) && (b == '1)));
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared 64-bit shift register with one 33-bit adder/subtractor and sign fix-up.
// Latency: one radix-2 step per cycle while step is high.
// Backpressure: none; sequenced entirely by the controller.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  op_e              op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    op_e                op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               special_q;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_load;
    logic [WIDTH-1:0]   opnd_load;

    always_comb begin
        sa    = op_a_signed(op) & op_a[WIDTH-1];
        sb    = op_b_signed(op) & op_b[WIDTH-1];
        mag_a = sa ? -op_a : op_a;
        mag_b = sb ? -op_b : op_b;
        // Divide-by-zero preloads {remainder, quotient} = {op_a, all ones}.
        if (op_is_div(op) && (op_b == '0)) begin
            acc_load  = {op_a, {WIDTH{1'b1}}};
            opnd_load = '0;
        end else if (op_is_div(op)) begin
            acc_load  = {{WIDTH{1'b0}}, mag_a};
            opnd_load = mag_b;
        end else begin
            acc_load  = {{WIDTH{1'b0}}, mag_b};
            opnd_load = mag_a;
        end
    end

    logic               is_mul;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_upper;
    logic               quo_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] acc_step;

    // Multiply adds into the upper half; divide subtracts from the shifted remainder.
    always_comb begin
        is_mul    = ~op_q[2];
        add_x     = is_mul ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} : acc_q[2*WIDTH-1:WIDTH-1];
        add_y     = is_mul ? {1'b0, opnd_q} : ~{1'b0, opnd_q};
        add_sum   = add_x + add_y + {{WIDTH{1'b0}}, ~is_mul};
        mul_upper = acc_q[0] ? add_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        quo_bit   = ~add_sum[WIDTH];
        rem_next  = quo_bit ? add_sum[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];
        if (is_mul) begin
            acc_step = {mul_upper, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {rem_next, acc_q[WIDTH-2:0], quo_bit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= OP_MUL;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            special_q <= 1'b0;
        end else if (load) begin
            acc_q     <= acc_load;
            opnd_q    <= opnd_load;
            op_q      <= op;
            sign_a_q  <= sa;
            sign_b_q  <= sb;
            special_q <= is_bypass(op, op_a, op_b);
        end else if (step) begin
            acc_q     <= acc_step;
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic               neg_quo;
    logic               neg_rem;

    always_comb begin
        prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        neg_quo = ~special_q & (sign_a_q ^ sign_b_q);
        neg_rem = ~special_q & sign_a_q;
        unique case (op_q)
            OP_MUL:                       result = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              result = neg_quo ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            OP_REM, OP_REMU:              result = neg_rem ? -acc_q[2*WIDTH-1:WIDTH]
                                                           : acc_q[2*WIDTH-1:WIDTH];
            default:                      result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_controller.sv
// Iterative RV32M multiply/divide unit: IDLE -> BUSY (32 steps) -> DONE.
// Latency: valid 33 cycles after accept, 1 cycle for divide-by-zero/overflow.
// Backpressure: stall holds the pipeline from accept until DONE; flush aborts.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               load;
    logic               step;
    op_e                op_in;
    logic [WIDTH-1:0]   dp_result;

    assign op_in = op_e'(funct3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (is_bypass(op_in, op_a, op_b)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            ST_BUSY: begin
                step  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Flush outranks acceptance and every transition.
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            load    = 1'b0;
            step    = 1'b0;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign valid  = (state_q == ST_DONE) && !flush;
    assign stall  = reset_n && (((state_q == ST_IDLE) && start && !flush) ||
                                (state_q == ST_BUSY));
    assign result = valid ? dp_result : '0;

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
        .op      (op_in),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (dp_result)
    );

endmodule
